// File: rtl/spi_master_pkg.sv
// Shared types, frame constants and width helpers for the SPI register-access initiator.
package spi_master_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SETUP = 3'd1,
    SHIFT = 3'd2,
    HOLD  = 3'd3,
    GAP   = 3'd4
  } state_e;

  localparam int FRAME_W    = 16;
  localparam int CMD_WR_BIT = 15;
  localparam int BIT_CNT_W  = $clog2(FRAME_W);

  // Bits needed for a counter that runs 0..n-1 (never narrower than 1).
  function automatic int cnt_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/spi_master_if_if.sv
// Request handshake and SPI pin bundle; master modport is the initiator, slave the requester/target side.
// Handshake: i_start is taken only on an edge where o_busy=0; o_busy stays high from the next cycle until
// the frame's gap has elapsed, and o_done pulses for one cycle (with o_rdata valid) when csn rises.
interface spi_master_bus_if #(
  parameter int ADDR_W = 7,
  parameter int DATA_W = 8
) ();
  logic              i_start;
  logic              i_wr;
  logic [ADDR_W-1:0] i_addr;
  logic [DATA_W-1:0] i_wdata;
  logic              o_busy;
  logic              o_done;
  logic [DATA_W-1:0] o_rdata;
  logic              o_csn;
  logic              o_sck;
  logic              o_mosi;
  logic              i_miso;

  modport master (
    input  i_start, i_wr, i_addr, i_wdata, i_miso,
    output o_busy, o_done, o_rdata, o_csn, o_sck, o_mosi
  );

  modport slave (
    output i_start, i_wr, i_addr, i_wdata, i_miso,
    input  o_busy, o_done, o_rdata, o_csn, o_sck, o_mosi
  );
endinterface

// File: rtl/spi_master_if_sck_gen.sv
// Serial clock divider: CLK_DIV cycles low then CLK_DIV cycles high per bit, ticks one cycle before each edge.
module spi_sck_gen
  import spi_master_pkg::*;
#(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic en_i,
  output logic sck_o,
  output logic rise_tick_o,
  output logic fall_tick_o
);
  localparam int DIV_W = cnt_w(2 * CLK_DIV);
  localparam logic [DIV_W-1:0] RISE_AT = DIV_W'(CLK_DIV - 1);
  localparam logic [DIV_W-1:0] FALL_AT = DIV_W'(2 * CLK_DIV - 1);

  logic [DIV_W-1:0] div_q, div_d;
  logic             sck_q, sck_d;

  // Ticks mark the last cycle of each phase, so sck_q changes on the edge that ends it.
  always_comb begin
    rise_tick_o = en_i && (div_q == RISE_AT);
    fall_tick_o = en_i && (div_q == FALL_AT);
    div_d       = div_q;
    sck_d       = sck_q;
    if (!en_i) begin
      div_d = '0;
      sck_d = 1'b0;
    end else begin
      div_d = fall_tick_o ? '0 : div_q + 1'b1;
      if (rise_tick_o)      sck_d = 1'b1;
      else if (fall_tick_o) sck_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      div_q <= '0;
      sck_q <= 1'b0;
    end else begin
      div_q <= div_d;
      sck_q <= sck_d;
    end
  end

  assign sck_o = sck_q;

endmodule

// File: rtl/spi_master_if.sv
// SPI mode-0 initiator for one 16-bit register read/write frame: {wr, addr} then data, MSB first.
module spi_master_if
  import spi_master_pkg::*;
#(
  parameter int CLK_DIV  = 4,
  parameter int ADDR_W   = 7,
  parameter int DATA_W   = 8,
  parameter int CS_SETUP = 2,
  parameter int CS_HOLD  = 2,
  parameter int CS_IDLE  = 2
) (
  input  logic             clk,
  input  logic             reset,
  spi_master_bus_if.master bus,
  output state_e           o_dbg_state
);
  localparam int PH_W = cnt_w(max3(CS_SETUP, CS_HOLD, CS_IDLE));
  localparam logic [PH_W-1:0]      SETUP_LAST = PH_W'(CS_SETUP - 1);
  localparam logic [PH_W-1:0]      HOLD_LAST  = PH_W'(CS_HOLD - 1);
  localparam logic [PH_W-1:0]      IDLE_LAST  = PH_W'(CS_IDLE - 1);
  localparam logic [BIT_CNT_W-1:0] BIT_LAST   = BIT_CNT_W'(FRAME_W - 1);

  state_e               state_q, state_d;
  logic [PH_W-1:0]      ph_q, ph_d;
  logic [BIT_CNT_W-1:0] bit_q, bit_d;
  logic [FRAME_W-1:0]   tx_q, tx_d;
  logic [DATA_W-1:0]    rx_q, rx_d;
  logic [DATA_W-1:0]    rdata_q, rdata_d;
  logic                 done_q, done_d;
  logic                 wr_q, wr_d;
  logic                 sck, rise_tick, fall_tick;

  spi_sck_gen #(.CLK_DIV(CLK_DIV)) u_sck_gen (
    .clk         (clk),
    .reset       (reset),
    .en_i        (state_q == SHIFT),
    .sck_o       (sck),
    .rise_tick_o (rise_tick),
    .fall_tick_o (fall_tick)
  );

  always_comb begin
    state_d = state_q;
    ph_d    = ph_q;
    bit_d   = bit_q;
    tx_d    = tx_q;
    rx_d    = rx_q;
    rdata_d = rdata_q;
    done_d  = 1'b0;
    wr_d    = wr_q;
    case (state_q)
      IDLE: begin
        if (bus.i_start) begin
          tx_d    = {bus.i_wr, bus.i_addr, bus.i_wr ? bus.i_wdata : {DATA_W{1'b0}}};
          wr_d    = bus.i_wr;
          ph_d    = '0;
          state_d = SETUP;
        end
      end
      SETUP: begin
        if (ph_q == SETUP_LAST) begin
          ph_d    = '0;
          bit_d   = '0;
          state_d = SHIFT;
        end else begin
          ph_d = ph_q + 1'b1;
        end
      end
      SHIFT: begin
        // Only the last DATA_W samples survive, so command-phase MISO bits fall out naturally.
        if (rise_tick) rx_d = {rx_q[DATA_W-2:0], bus.i_miso};
        if (fall_tick) begin
          tx_d  = {tx_q[FRAME_W-2:0], 1'b0};
          bit_d = bit_q + 1'b1;
          if (bit_q == BIT_LAST) state_d = HOLD;
        end
      end
      HOLD: begin
        if (ph_q == HOLD_LAST) begin
          ph_d    = '0;
          done_d  = 1'b1;
          state_d = GAP;
          if (!wr_q) rdata_d = rx_q;
        end else begin
          ph_d = ph_q + 1'b1;
        end
      end
      GAP: begin
        if (ph_q == IDLE_LAST) begin
          ph_d    = '0;
          state_d = IDLE;
        end else begin
          ph_d = ph_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      ph_q    <= '0;
      bit_q   <= '0;
      tx_q    <= '0;
      rx_q    <= '0;
      rdata_q <= '0;
      done_q  <= 1'b0;
      wr_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      ph_q    <= ph_d;
      bit_q   <= bit_d;
      tx_q    <= tx_d;
      rx_q    <= rx_d;
      rdata_q <= rdata_d;
      done_q  <= done_d;
      wr_q    <= wr_d;
    end
  end

  // tx_q has shifted in zeros by the end of the frame, so mosi idles low without extra gating.
  assign bus.o_mosi  = tx_q[FRAME_W-1];
  assign bus.o_sck   = sck;
  assign bus.o_csn   = !(state_q == SETUP || state_q == SHIFT || state_q == HOLD);
  assign bus.o_busy  = (state_q != IDLE);
  assign bus.o_done  = done_q;
  assign bus.o_rdata = rdata_q;
  assign o_dbg_state = state_q;

endmodule

// File: tb/tb_spi_master_if.sv
// Bench for spi_master_if: default-timing instance plus a CLK_DIV=1 / minimal-guard instance.
module tb_spi_master_if;
  import spi_master_pkg::*;

  localparam int A_DIV = 4, A_S = 2, A_H = 2, A_I = 2;
  localparam int B_DIV = 1, B_S = 1, B_H = 1, B_I = 1;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       st = 1'b0;
  logic       wr = 1'b0;
  logic [6:0] addr = '0;
  logic [7:0] wdata = '0;
  logic       miso = 1'b0;
  logic       sel = 1'b0;
  state_e     dbg_a, dbg_b;

  int checks = 0;
  int errors = 0;
  logic [15:0] exp_q[$];
  logic [7:0]  exp_rd_q[$];
  logic [7:0]  model_rd_a = 8'h00;
  logic [7:0]  model_rd_b = 8'h00;

  spi_master_bus_if #(.ADDR_W(7), .DATA_W(8)) ifa ();
  spi_master_bus_if #(.ADDR_W(7), .DATA_W(8)) ifb ();

  spi_master_if #(.CLK_DIV(A_DIV), .ADDR_W(7), .DATA_W(8), .CS_SETUP(A_S), .CS_HOLD(A_H), .CS_IDLE(A_I))
    dut_a (.clk(clk), .reset(reset), .bus(ifa), .o_dbg_state(dbg_a));
  spi_master_if #(.CLK_DIV(B_DIV), .ADDR_W(7), .DATA_W(8), .CS_SETUP(B_S), .CS_HOLD(B_H), .CS_IDLE(B_I))
    dut_b (.clk(clk), .reset(reset), .bus(ifb), .o_dbg_state(dbg_b));

  assign ifa.i_start = st & ~sel;
  assign ifa.i_wr    = wr;
  assign ifa.i_addr  = addr;
  assign ifa.i_wdata = wdata;
  assign ifa.i_miso  = miso;
  assign ifb.i_start = st & sel;
  assign ifb.i_wr    = wr;
  assign ifb.i_addr  = addr;
  assign ifb.i_wdata = wdata;
  assign ifb.i_miso  = miso;

  wire       m_csn   = sel ? ifb.o_csn   : ifa.o_csn;
  wire       m_sck   = sel ? ifb.o_sck   : ifa.o_sck;
  wire       m_mosi  = sel ? ifb.o_mosi  : ifa.o_mosi;
  wire       m_busy  = sel ? ifb.o_busy  : ifa.o_busy;
  wire       m_done  = sel ? ifb.o_done  : ifa.o_done;
  wire [7:0] m_rdata = sel ? ifb.o_rdata : ifa.o_rdata;

  // clock / watchdog
  always #5 clk = ~clk;
  initial begin
    #3_000_000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Reference: frame contents and timing follow directly from the request and the timing parameters.
  function automatic logic [15:0] model_frame(input logic w, input logic [6:0] a, input logic [7:0] d);
    return {w, a, (w ? d : 8'h00)};
  endfunction

  // Drives one request, acts as mode-0 slave returning resp MSB first, and checks frame timing.
  task automatic txn(input logic t_wr, input logic [6:0] t_addr, input logic [7:0] t_wdata,
                     input logic [15:0] resp, input bit gap_poke,
                     output logic [15:0] mosi_word, output logic [7:0] rd_at_done);
    int d  = sel ? B_DIV : A_DIV;
    int s  = sel ? B_S : A_S;
    int h  = sel ? B_H : A_H;
    int id = sel ? B_I : A_I;
    int exp_done = s + 32 * d + h + 1;
    int cyc = 0, csn_low = 0, pulses = 0, hi_run = 0, bad_w = 0;
    int done_cyc = -1, done_n = 0, busy_fall = -1, rx_bit = 15;
    logic prev_sck = 1'b0;
    mosi_word  = '0;
    rd_at_done = '0;
    @(negedge clk);
    st = 1'b1; wr = t_wr; addr = t_addr; wdata = t_wdata;
    while (busy_fall < 0 && cyc < 1000) begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) begin
        st = 1'b0;
        wr = 1'($urandom); addr = 7'($urandom); wdata = 8'($urandom);
        check("first_cycle_csn_busy_mosi", {m_csn, m_busy, m_mosi}, {1'b0, 1'b1, t_wr});
        miso = resp[15];
      end
      if (gap_poke) begin
        if (cyc == exp_done + 1)      st = 1'b1;
        else if (cyc == exp_done + 2) st = 1'b0;
      end
      if (!m_csn) csn_low++;
      if (m_sck && !prev_sck) begin
        mosi_word = {mosi_word[14:0], m_mosi};
        pulses++;
        hi_run = 0;
      end
      if (m_sck) hi_run++;
      if (!m_sck && prev_sck) begin
        if (hi_run != d) bad_w++;
        rx_bit--;
        if (rx_bit >= 0) miso = resp[rx_bit];
      end
      if (m_done) begin
        done_n++;
        done_cyc   = cyc;
        rd_at_done = m_rdata;
      end
      if (!m_busy) busy_fall = cyc;
      prev_sck = m_sck;
    end
    st = 1'b0;
    check("sck_pulses", pulses, 16);
    check("sck_high_width_errs", bad_w, 0);
    check("csn_low_cycles", csn_low, s + 32 * d + h);
    check("done_cycle", done_cyc, exp_done);
    check("done_pulses", done_n, 1);
    check("busy_fall_cycle", busy_fall, exp_done + id);
  endtask

  typedef struct {
    logic       wr;
    logic [6:0] addr;
    logic [7:0] wdata;
    logic [15:0] resp;
    logic [15:0] exp_mosi;
    logic [7:0]  exp_rdata;
  } vec_t;

  vec_t vecs[4];

  initial begin
    logic [15:0] mw;
    logic [7:0]  rd;
    int falls, last_busy_fall, last_csn_rise, extra;
    logic prev_csn, prev_busy, prev_sck;

    vecs[0] = '{1'b1, 7'h05, 8'hA5, 16'h0000, 16'h85A5, 8'h00};
    vecs[1] = '{1'b0, 7'h02, 8'h00, 16'h5A3C, 16'h0200, 8'h3C};
    vecs[2] = '{1'b1, 7'h7F, 8'h00, 16'h1234, 16'hFF00, 8'h3C};
    vecs[3] = '{1'b0, 7'h7F, 8'h77, 16'hFFC3, 16'h7F00, 8'hC3};

    // reset state
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("reset_a_outputs", {ifa.o_csn, ifa.o_sck, ifa.o_mosi, ifa.o_busy, ifa.o_done, ifa.o_rdata},
          {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00});
    check("reset_b_outputs", {ifb.o_csn, ifb.o_sck, ifb.o_mosi, ifb.o_busy, ifb.o_done, ifb.o_rdata},
          {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00});
    check("reset_a_state", dbg_a, IDLE);

    // directed table on default instance
    sel = 1'b0;
    for (int i = 0; i < 4; i++) begin
      txn(vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].resp, 1'b0, mw, rd);
      check($sformatf("vec%0d_mosi", i), mw, vecs[i].exp_mosi);
      check($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rdata);
    end
    model_rd_a = 8'hC3;

    // reset in the middle of SHIFT, after bit 5 has been sent
    @(negedge clk);
    st = 1'b1; wr = 1'b0; addr = 7'h33;
    falls = 0; prev_sck = 1'b0; extra = 0;
    while (falls < 11 && extra < 1000) begin
      @(negedge clk);
      st = 1'b0;
      extra++;
      if (prev_sck && !m_sck) falls++;
      prev_sck = m_sck;
    end
    check("midreset_reached_bit5", falls, 11);
    reset = 1'b1;
    @(negedge clk);
    check("midreset_outputs", {m_csn, m_sck, m_mosi, m_busy, m_done, m_rdata},
          {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00});
    reset = 1'b0;
    model_rd_a = 8'h00;
    model_rd_b = 8'h00;
    extra = 0;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (m_done || !m_csn) extra++;
    end
    check("midreset_no_done_no_csn", extra, 0);
    txn(1'b0, 7'h44, 8'h00, 16'h00E7, 1'b0, mw, rd);
    check("post_reset_mosi", mw, 16'h4400);
    check("post_reset_rdata", rd, 8'hE7);
    model_rd_a = 8'hE7;

    // randomized transactions against the model
    for (int n = 0; n < 16; n++) begin
      logic       r_wr;
      logic [6:0] r_addr;
      logic [7:0] r_wdata;
      logic [15:0] r_resp;
      r_wr    = 1'($urandom);
      r_addr  = 7'($urandom_range(0, 127));
      r_wdata = 8'($urandom);
      r_resp  = 16'($urandom);
      exp_q.push_back(model_frame(r_wr, r_addr, r_wdata));
      if (!r_wr) model_rd_a = r_resp[7:0];
      exp_rd_q.push_back(model_rd_a);
      txn(r_wr, r_addr, r_wdata, r_resp, 1'b0, mw, rd);
      check($sformatf("rand%0d_mosi", n), mw, exp_q.pop_front());
      check($sformatf("rand%0d_rdata", n), rd, exp_rd_q.pop_front());
    end

    // back-to-back: start held high for 300 cycles
    @(negedge clk);
    st = 1'b1; wr = 1'b1; addr = 7'h01; wdata = 8'h5A; miso = 1'b0;
    prev_csn = 1'b1; prev_busy = 1'b0; falls = 0; last_busy_fall = -1000; last_csn_rise = -1000;
    for (int c = 1; c <= 300; c++) begin
      @(negedge clk);
      if (prev_csn && !m_csn) begin
        falls++;
        if (falls > 1) begin
          check("b2b_start_after_busy_fall", c - last_busy_fall, 1);
          check("b2b_csn_high_ge_idle", (c - last_csn_rise) >= A_I, 1);
        end
      end
      if (prev_busy && !m_busy) last_busy_fall = c;
      if (!prev_csn && m_csn) last_csn_rise = c;
      prev_csn  = m_csn;
      prev_busy = m_busy;
    end
    st = 1'b0;
    check("b2b_frames_in_300", falls, 3);
    extra = 0;
    while (m_busy && extra < 400) begin
      @(negedge clk);
      extra++;
    end
    check("b2b_drained", m_busy, 1'b0);
    check("b2b_rdata_unchanged", m_rdata, model_rd_a);

    // start during GAP is ignored
    txn(1'b1, 7'h0F, 8'h3C, 16'h0000, 1'b1, mw, rd);
    check("gap_poke_mosi", mw, 16'h8F3C);
    extra = 0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (!m_csn || m_busy) extra++;
    end
    check("gap_poke_ignored", extra, 0);

    // CLK_DIV=1 instance with minimal guard times
    sel = 1'b1;
    txn(1'b0, 7'h11, 8'h00, 16'hFFFF, 1'b0, mw, rd);
    check("div1_read_mosi", mw, 16'h1100);
    check("div1_read_rdata", rd, 8'hFF);
    model_rd_b = 8'hFF;
    txn(1'b1, 7'h2A, 8'h96, 16'h0000, 1'b0, mw, rd);
    check("div1_write_mosi", mw, model_frame(1'b1, 7'h2A, 8'h96));
    check("div1_write_rdata", rd, model_rd_b);
    for (int n = 0; n < 4; n++) begin
      logic [6:0]  r_addr;
      logic [15:0] r_resp;
      r_addr = 7'($urandom);
      r_resp = 16'($urandom);
      txn(1'b0, r_addr, 8'h00, r_resp, 1'b0, mw, rd);
      check($sformatf("div1_rand%0d_mosi", n), mw, model_frame(1'b0, r_addr, 8'h00));
      check($sformatf("div1_rand%0d_rdata", n), rd, r_resp[7:0]);
    end

    // final report
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/spi_master_if.md
Name: spi_master_if

Overview:
- SPI initiator for the on-chip SPI slave/register-file domain; used as the bench-side and SoC-side driver of the register-file access protocol.
- Accepts one register read or write request through a start/busy/done handshake.
- Serialises a 16-bit frame, mode 0 (CPOL=0, CPHA=0), MSB first: byte 0 = {wr, addr[6:0]}, byte 1 = write data (write) or don't-care with MISO captured (read).
- Generates csn, sck and mosi from the single system clock.

Parameters:
- CLK_DIV, 4, system-clock cycles per sck half-period; legal range >= 1.
- ADDR_W, 7, register address width.
- DATA_W, 8, data width.
- CS_SETUP, 2, cycles from csn falling to first sck rising edge region (SETUP state length); legal range >= 1.
- CS_HOLD, 2, cycles from last sck falling edge to csn rising; legal range >= 1.
- CS_IDLE, 2, minimum csn-high cycles between frames; legal range >= 1.

Ports:
- clk, input, 1, system clock.
- reset, input, 1, synchronous reset, active-high.
- i_start, input, 1, request strobe; accepted only when o_busy=0.
- i_wr, input, 1, 1 = write, 0 = read.
- i_addr, input, ADDR_W, register address.
- i_wdata, input, DATA_W, write data.
- o_busy, output, 1, transaction in progress.
- o_done, output, 1, one-cycle completion pulse.
- o_rdata, output, DATA_W, captured read data.
- o_csn, output, 1, chip select, active-low.
- o_sck, output, 1, serial clock.
- o_mosi, output, 1, serial data out.
- i_miso, input, 1, serial data in.

Behaviour:
- Interface (fixed): one clock, clk; reset is synchronous and active-high, named reset.
- Reset values: o_csn=1, o_sck=0, o_mosi=0, o_busy=0, o_done=0, o_rdata=0, FSM=IDLE, all counters=0.
- Reset mid-frame: on the next edge the outputs return to their reset values, no o_done pulse, o_rdata cleared.
- FSM states: IDLE -> SETUP -> SHIFT -> HOLD -> GAP -> IDLE.
- IDLE:
  - i_start=1 at edge T0 latches shift register {i_wr, i_addr, i_wdata}; for a read, the low byte is sent as 0.
  - At T0+1: state=SETUP, o_csn=0, o_busy=1, o_mosi=frame bit 15.
  - i_start while o_busy=1 is ignored; no queueing.
- SETUP:
  - CS_SETUP cycles, sck low, then SHIFT.
- SHIFT:
  - 16 bits, 2*CLK_DIV cycles each.
  - First CLK_DIV cycles sck=0, next CLK_DIV cycles sck=1.
  - i_miso is sampled on the cycle sck rises and shifted into the receive register.
  - On the cycle sck falls, mosi advances to the next bit.
  - After bit 0's high phase: sck=0, mosi=0, state=HOLD.
  - Length is exactly 32*CLK_DIV cycles.
- HOLD:
  - CS_HOLD cycles, csn low, sck low.
- Completion (GAP entry):
  - o_csn=1 and o_done=1 for exactly one cycle.
  - For reads, o_rdata = the 8 bits sampled during frame bits 7..0 (MSB first) in the same cycle.
  - Writes leave o_rdata unchanged.
- GAP:
  - CS_IDLE cycles, then IDLE with o_busy=0.
  - A new i_start is accepted on the first edge with o_busy=0.
- Timing with defaults:
  - csn low for 2+128+2 = 132 cycles.
  - o_done at T0+133.
  - o_busy falls at T0+135.
- i_addr, i_wr and i_wdata are don't-care after T0.
- Bits sampled during command bits 15..8 are discarded.
- CLK_DIV=1 must work: sck toggles every cycle.

Decomposition:
- Package spi_master_pkg holds:
  - state enum (IDLE, SETUP, SHIFT, HOLD, GAP);
  - FRAME_W=16;
  - CMD_WR_BIT=15;
  - localparam widths for the divider and bit counters.
- Sub-module spi_sck_gen:
  - divider counter producing o_sck, a rise_tick and a fall_tick;
  - enabled only in SHIFT;
  - synchronous clear on reset or when not enabled.
- Top holds the FSM, shift registers and the setup/hold/gap counter.

Test Plan:
1. Write: i_wr=1, i_addr=7'h05, i_wdata=8'hA5, defaults -> mosi sequence 0x85A5 MSB first, sampled on sck rises; 16 sck pulses, each high 4 cycles; csn low 132 cycles; o_done at T0+133; o_rdata unchanged (0).
2. Read: i_wr=0, i_addr=7'h02; bench slave model drives MISO 0x3C on the data byte (changes on sck fall) -> mosi 0x0200; o_rdata=8'h3C in the o_done cycle; single o_done pulse.
3. Back-to-back: i_start held high for 300 cycles -> second frame starts exactly 1 cycle after o_busy falls; csn high >= 2 cycles between frames; no start accepted while busy.
4. Reset mid-SHIFT after bit 5 -> next edge: csn=1, sck=0, mosi=0, busy=0, o_rdata=0; no o_done; a fresh request then completes normally.
5. CLK_DIV=1, CS_SETUP=CS_HOLD=CS_IDLE=1 -> sck toggles every cycle, 32 SHIFT cycles, o_done at T0+35, read data 8'hFF with MISO held high.
6. Start during GAP (the cycle after o_done) -> ignored; no csn re-assertion until the following request after o_busy=0.
